funct_generator_mc: RTL and testbench
=====================================

# funct_generator_mc

Multi-channel successor to the single-channel function generator. Produces NUM_CH independent waveform streams (sine, cosine, triangle, square), each with its own phase step and signed amplitude. Streams are time-multiplexed round-robin onto one sample port feeding the downstream FIFO write side. A two-stage pipeline stalls on FIFO full without losing or duplicating samples.

## Interface

Parameters:
- DATA_WIDTH, 16, sample width (signed, full scale ±(2^(DATA_WIDTH-1)-1))
- INT_BITS, 8, signed integer amplitude width
- LUT_ADDR, 6, LUT address bits (LUT depth 2^LUT_ADDR)
- PHASE_W, 16, per-channel phase accumulator width (≥ LUT_ADDR)
- NUM_CH, 4, channel count (≥ 2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en_low_i  in  1  active-low generator enable
- cfg_we_i  in  1  config write strobe, single cycle
- cfg_ch_i  in  $clog2(NUM_CH)  channel being configured
- cfg_sel_i  in  2  waveform select: 00 sine, 01 cosine, 10 triangle, 11 square
- cfg_amp_i  in  INT_BITS  signed amplitude multiplier
- cfg_step_i  in  PHASE_W  phase increment per sample of that channel
- full_i  in  1  downstream FIFO full
- wr_en_o  out  1  FIFO write strobe
- ch_o  out  $clog2(NUM_CH)  channel of data_o
- data_o  out  DATA_WIDTH  signed sample

## Operation

- Per-channel registers: sel, amp, step, phase accumulator.
- Reset clears all of them to 0, sets state IDLE, and sets wr_en_o=0, ch_o=0, data_o=0.
- FSM:
  - IDLE → GEN when en_low_i=0.
  - GEN → STALL when full_i=1.
  - STALL → GEN when full_i=0.
  - Any state → IDLE when en_low_i=1. This flushes pipeline valids and holds phases and the round-robin pointer.
- Issue, in GEN only when the pipeline can advance: one channel per cycle, pointer 0,1,…,NUM_CH-1,0.
- The issued channel's phase updates as acc ← acc + step, modulo 2^PHASE_W. The pre-increment value is used for the sample.
- Address a = acc[PHASE_W-1 -: LUT_ADDR]; N = 2^LUT_ADDR; FS = 2^(DATA_WIDTH-1)-1.
- Raw waveform shapes:
  - Sine: LUT[a] = round(FS·sin(2πa/N)).
  - Cosine: LUT[(a+N/4) mod N].
  - Triangle: u = a[LUT_ADDR-2:0] << (DATA_WIDTH-LUT_ADDR+1); r = u − 2^(DATA_WIDTH-1); output r if a MSB=0, else ~r.
  - Square: +FS if a MSB=0, else −FS.
- Scaling: product = raw × amp, full precision (DATA_WIDTH+INT_BITS bits), saturated to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]. amp=0 gives 0 samples, which are still emitted.
- Config writes are accepted in every state.
  - A write loads sel, amp, step and sets the channel's accumulator to 0.
  - The write overrides a same-cycle advance of that channel.
  - A sample issued in the same cycle uses the old config.
  - cfg_ch_i ≥ NUM_CH: write ignored.

## Timing

- Pipeline stage 1 (issue, accumulator, shape) and stage 2 (multiply, saturate, output register).
- Latency: issue at edge k → data_o/ch_o valid after edge k+1.
- Start-up: FSM enters GEN at edge E, ch0 issued at E+1, and the first wr_en_o=1 appears after E+2.
- wr_en_o = stage-2 valid AND NOT full_i. This is the only combinational path.
  - wr_en_o is never high while full_i=1.
  - While full_i=1, both stages and all accumulators hold, and data_o/ch_o stay stable.
- Steady state with full_i=0: one sample per clock, ch_o strictly cyclic.
- rst asserted mid-stream: all outputs return to 0 on the next edge and in-flight samples are discarded.

## Configuration

- FGEN_PHASE_OFFSET_EN: when defined, the block adds port cfg_phase_i (in, PHASE_W). A config write then loads the channel accumulator with cfg_phase_i instead of 0.
- When undefined, the port is absent and the accumulator loads 0.
- All other behaviour is identical.

## Test plan

- Reset, no config, en_low_i=0: wr_en_o first high after E+2, ch_o 0,1,2,3,0…, data_o all 0.
- ch0 square, amp=1, step=32768: ch0 samples 32767, −32767, 32767, …
- ch1 sine, amp=1, step=16384 (addresses 0,16,32,48): ch1 samples 0, 32767, 0, −32767.
- ch2 square, amp=4 → 32767/−32768 (saturated); amp=−1 → −32767/32767.
- full_i held high 5 cycles mid-stream: wr_en_o=0 and data_o/ch_o stable throughout; after release, the channel/sample sequence continues with no gap or repeat.
- With FGEN_PHASE_OFFSET_EN, ch3 sine, step=0, cfg_phase_i=16384: ch3 constant 32767. Then en_low_i=1 → wr_en_o=0 within one cycle, and the stream resumes at the held pointer when re-enabled.

Source files
------------

// File: rtl/funct_generator_mc.sv
// funct_generator_mc: NUM_CH round-robin sine/cosine/triangle/square generator feeding a FIFO through a stallable 2-stage pipeline.
// Optional build macro FGEN_PHASE_OFFSET_EN adds cfg_phase_i, which preloads the channel accumulator on a config write.
module funct_generator_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int INT_BITS   = 8,
    parameter int LUT_ADDR   = 6,
    parameter int PHASE_W    = 16,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_low_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_ch_i,
    input  logic [1:0]                   cfg_sel_i,
    input  logic signed [INT_BITS-1:0]   cfg_amp_i,
    input  logic [PHASE_W-1:0]           cfg_step_i,
`ifdef FGEN_PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0]           cfg_phase_i,
`endif
    input  logic                         full_i,
    output logic                         wr_en_o,
    output logic [$clog2(NUM_CH)-1:0]    ch_o,
    output logic signed [DATA_WIDTH-1:0] data_o
);
    localparam int CW     = $clog2(NUM_CH);
    localparam int LUT_N  = 1 << LUT_ADDR;
    localparam int PROD_W = DATA_WIDTH + INT_BITS;
    localparam logic signed [DATA_WIDTH-1:0] FS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(FS);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(DMIN);
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic [1:0] {IDLE, GEN, STALL} state_t;

    // Elaboration-time sine in Q30 fixed point (quarter-wave reduced Taylor series), rounded half away from zero.
    function automatic longint sine_point(input int a);
        longint x, term, sum, t;
        int     aq;
        logic   neg;
        neg = (a >= LUT_N / 2);
        aq  = a % (LUT_N / 2);
        if (aq > LUT_N / 4) aq = LUT_N / 2 - aq;
        x    = (PI_Q30 * 2 * longint'(aq)) / longint'(LUT_N);
        term = x;
        sum  = 0;
        for (int unsigned k = 0; k < 10; k++) begin
            sum  = sum + term;
            t    = (term * x) >>> 30;
            t    = (t * x) >>> 30;
            term = -t / longint'((2 * k + 2) * (2 * k + 3));
        end
        sum = (sum * longint'(FS) + (64'sd1 <<< 29)) >>> 30;
        return neg ? -sum : sum;
    endfunction

    logic signed [DATA_WIDTH-1:0] sin_lut [LUT_N];
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam logic signed [DATA_WIDTH-1:0] V = DATA_WIDTH'(sine_point(gi));
        assign sin_lut[gi] = V;
    end

    state_t                     state_q, state_d;
    logic [1:0]                 sel_q  [NUM_CH];
    logic signed [INT_BITS-1:0] amp_q  [NUM_CH];
    logic [PHASE_W-1:0]         step_q [NUM_CH];
    logic [PHASE_W-1:0]         acc_q  [NUM_CH];
    logic [CW-1:0]              rr_q;

    logic                         s1_valid, s2_valid;
    logic [CW-1:0]                s1_ch;
    logic signed [DATA_WIDTH-1:0] s1_raw;
    logic signed [INT_BITS-1:0]   s1_amp;

    logic                         issue, cfg_hit;
    logic [PHASE_W-1:0]           acc_load;
    logic [LUT_ADDR-1:0]          addr, cos_addr;
    logic [DATA_WIDTH-1:0]        tri_u, tri_r;
    logic signed [DATA_WIDTH-1:0] raw, sat;
    logic signed [PROD_W-1:0]     prod;

`ifdef FGEN_PHASE_OFFSET_EN
    assign acc_load = cfg_phase_i;
`else
    assign acc_load = '0;
`endif

    assign cfg_hit = cfg_we_i && (32'(cfg_ch_i) < NUM_CH);
    assign wr_en_o = s2_valid && !full_i;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (en_low_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = GEN;
                GEN: begin
                    issue = !full_i;
                    if (full_i) state_d = STALL;
                end
                STALL:   if (!full_i) state_d = GEN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 1 shaping from the pre-increment accumulator of the channel being issued.
    always_comb begin
        addr     = acc_q[rr_q][PHASE_W-1 -: LUT_ADDR];
        cos_addr = addr + LUT_ADDR'(LUT_N / 4);
        tri_u    = DATA_WIDTH'(addr[LUT_ADDR-2:0]) << (DATA_WIDTH - LUT_ADDR + 1);
        tri_r    = tri_u - DMIN;
        raw      = '0;
        case (sel_q[rr_q])
            2'b00:   raw = sin_lut[addr];
            2'b01:   raw = sin_lut[cos_addr];
            2'b10:   raw = addr[LUT_ADDR-1] ? signed'(~tri_r) : signed'(tri_r);
            default: raw = addr[LUT_ADDR-1] ? -FS : FS;
        endcase
    end

    always_comb begin
        prod = PROD_W'(s1_raw) * PROD_W'(s1_amp);
        sat  = prod[DATA_WIDTH-1:0];
        if (prod > SAT_MAX)      sat = FS;
        else if (prod < SAT_MIN) sat = DMIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '{default: '0};
            amp_q    <= '{default: '0};
            step_q   <= '{default: '0};
            acc_q    <= '{default: '0};
            rr_q     <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_raw   <= '0;
            s1_amp   <= '0;
            s2_valid <= 1'b0;
            ch_o     <= '0;
            data_o   <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                acc_q[rr_q] <= acc_q[rr_q] + step_q[rr_q];
                rr_q        <= (32'(rr_q) == NUM_CH - 1) ? '0 : rr_q + CW'(1);
            end
            // Later assignment wins: a config write overrides a same-cycle advance.
            if (cfg_hit) begin
                sel_q[cfg_ch_i]  <= cfg_sel_i;
                amp_q[cfg_ch_i]  <= cfg_amp_i;
                step_q[cfg_ch_i] <= cfg_step_i;
                acc_q[cfg_ch_i]  <= acc_load;
            end
            if (en_low_i) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else if (!full_i) begin
                s1_valid <= issue;
                if (issue) begin
                    s1_ch  <= rr_q;
                    s1_raw <= raw;
                    s1_amp <= amp_q[rr_q];
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    ch_o   <= s1_ch;
                    data_o <= sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_funct_generator_mc.sv
// Scoreboard bench for funct_generator_mc: randomized stimulus, spec-level reference model, decoupled output monitor.
module tb_funct_generator_mc;
    localparam int DW  = 16;
    localparam int IB  = 8;
    localparam int LA  = 6;
    localparam int PW  = 16;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int N   = 1 << LA;
    localparam int FS  = (1 << (DW - 1)) - 1;
`ifdef FGEN_PHASE_OFFSET_EN
    localparam bit PHASE_EN = 1'b1;
`else
    localparam bit PHASE_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_GEN = 1, M_STALL = 2;

    logic clk = 1'b0;
    logic rst, en_low, cfg_we, full;
    logic [CW-1:0] cfg_ch;
    logic [1:0] cfg_sel;
    logic signed [IB-1:0] cfg_amp;
    logic [PW-1:0] cfg_step, cfg_phase;
    logic wr_en;
    logic [CW-1:0] ch;
    logic signed [DW-1:0] data;

    always #5 clk = ~clk;

    funct_generator_mc #(.DATA_WIDTH(DW), .INT_BITS(IB), .LUT_ADDR(LA), .PHASE_W(PW), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .en_low_i(en_low), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_sel_i(cfg_sel), .cfg_amp_i(cfg_amp), .cfg_step_i(cfg_step),
`ifdef FGEN_PHASE_OFFSET_EN
        .cfg_phase_i(cfg_phase),
`endif
        .full_i(full), .wr_en_o(wr_en), .ch_o(ch), .data_o(data)
    );

    typedef struct { int ch; int val; } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0;

    int m_sel[NCH], m_amp[NCH], m_ptr, m_state;
    logic [PW-1:0] m_step[NCH], m_acc[NCH];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sine_ref(input int a);
        real v;
        v = FS * $sin(2.0 * 3.141592653589793 * a / N);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int ref_sample(input int sel, input int amp, input int phase);
        int a, raw, p;
        a = phase >> (PW - LA);
        case (sel)
            0: raw = sine_ref(a);
            1: raw = sine_ref((a + N / 4) % N);
            2: begin
                raw = (a % (N / 2)) * (1 << (DW - LA + 1)) - (1 << (DW - 1));
                if (a >= N / 2) raw = -raw - 1;
            end
            default: raw = (a < N / 2) ? FS : -FS;
        endcase
        p = raw * amp;
        if (p > FS) p = FS;
        if (p < -FS - 1) p = -FS - 1;
        return p;
    endfunction

    // Applies the spec rules for one rising edge using the inputs the bench is driving.
    task automatic model_edge();
        bit issue;
        int c;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_sel[i] = 0; m_amp[i] = 0; m_step[i] = '0; m_acc[i] = '0;
            end
            m_ptr = 0;
            m_state = M_IDLE;
            q.delete();
            return;
        end
        issue = (m_state == M_GEN) && !en_low && !full;
        if (issue) begin
            q.push_back('{m_ptr, ref_sample(m_sel[m_ptr], m_amp[m_ptr], int'(m_acc[m_ptr]))});
            m_acc[m_ptr] = m_acc[m_ptr] + m_step[m_ptr];
            m_ptr = (m_ptr + 1) % NCH;
            chk("backlog_le2", int'(q.size() <= 2), 1);
        end
        if (cfg_we) begin
            c = int'(cfg_ch);
            m_sel[c]  = int'(cfg_sel);
            m_amp[c]  = int'(cfg_amp);
            m_step[c] = cfg_step;
            m_acc[c]  = PHASE_EN ? cfg_phase : '0;
        end
        if (en_low) begin
            m_state = M_IDLE;
            q.delete();
        end else if (m_state == M_IDLE) m_state = M_GEN;
        else m_state = full ? M_STALL : M_GEN;
    endtask

    task automatic cyc(input bit r, input bit el, input bit f, input bit we, input int c,
                       input int s, input int a, input int st, input int ph);
        rst = r; en_low = el; full = f; cfg_we = we;
        cfg_ch = CW'(c); cfg_sel = 2'(s); cfg_amp = IB'(a); cfg_step = PW'(st); cfg_phase = PW'(ph);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n, input bit el, input bit f);
        for (int i = 0; i < n; i++) cyc(1'b0, el, f, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input bit el, input int c, input int s, input int a, input int st, input int ph);
        cyc(1'b0, el, 1'b0, 1'b1, c, s, a, st, ph);
    endtask

    logic prev_full = 1'b0, prev_rst = 1'b1;
    logic signed [DW-1:0] prev_data;
    logic [CW-1:0] prev_ch;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (full) chk("wr_en_while_full", int'(wr_en), 0);
            if (full && prev_full && !prev_rst) begin
                chk("data_hold", int'(data), int'(prev_data));
                chk("ch_hold", int'(ch), int'(prev_ch));
            end
            if (wr_en === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got ch %0d data %0d expected no write at %0t", ch, data, $time);
                end else begin
                    e = q.pop_front();
                    chk("sample_ch", int'(ch), e.ch);
                    chk("sample_data", int'(data), e.val);
                end
            end
        end
        prev_full = full; prev_rst = rst; prev_data = data; prev_ch = ch;
    end

    initial begin
        bit r, el, f, we;
        rst = 1'b1; en_low = 1'b1; full = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_sel = '0; cfg_amp = '0; cfg_step = '0; cfg_phase = '0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_ch", int'(ch), 0);
        chk("reset_data", int'(data), 0);

        // Start-up latency: enter GEN at E, ch0 issued at E+1, first write after E+2.
        run(1, 1'b0, 1'b0);
        chk("startup_E", int'(wr_en), 0);
        run(1, 1'b0, 1'b0);
        chk("startup_E1", int'(wr_en), 0);
        run(1, 1'b0, 1'b0);
        chk("startup_E2_wr", int'(wr_en), 1);
        chk("startup_E2_ch", int'(ch), 0);
        run(12, 1'b0, 1'b0);

        // Directed shapes, configured while disabled.
        cfg(1'b1, 0, 3, 1, 32768, 0);
        cfg(1'b1, 1, 0, 1, 16384, 0);
        cfg(1'b1, 2, 3, 4, 32768, 0);
        cfg(1'b1, 3, 2, 1, 1024, 0);
        run(24, 1'b0, 1'b0);
        run(5, 1'b0, 1'b1);
        run(12, 1'b0, 1'b0);
        cfg(1'b0, 2, 3, -1, 32768, 0);
        run(12, 1'b0, 1'b0);
        cfg(1'b0, 3, 0, 1, 0, 16384);
        run(12, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        chk("disable_wr_en", int'(wr_en), 0);
        run(3, 1'b1, 1'b0);
        run(12, 1'b0, 1'b0);

        // Mid-stream reset.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        chk("midreset_wr_en", int'(wr_en), 0);
        chk("midreset_ch", int'(ch), 0);
        chk("midreset_data", int'(data), 0);
        run(8, 1'b0, 1'b0);

        for (int i = 0; i < 1200; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            el = ($urandom_range(0, 29) == 0);
            f  = ($urandom_range(0, 3) == 0);
            we = ($urandom_range(0, 7) == 0);
            cyc(r, el, f, we, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)),
                $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 64)) * 1024,
                int'($urandom_range(0, 65535)));
        end
        run(6, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
